imem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the byte-wide instruction memory. It shares one synchronous byte read port between the fetch requester and the data/debug requester. For each granted request it issues four consecutive byte reads and assembles a 32-bit word, with the lowest-addressed byte in the most significant position. It sits between the fetch stage, the load/debug path and the instruction memory array.

---
 rtl/imem_arbiter.sv | 95 +++++++++
 tb/tb_imem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin two-port arbiter sequencing four byte reads into one 32-bit word
module imem_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_req,
  input  logic [31:0]              f_addr,
  output logic                     f_ack,
  output logic [31:0]              f_rdata,
  input  logic                     d_req,
  input  logic [31:0]              d_addr,
  output logic                     d_ack,
  output logic [31:0]              d_rdata,
  output logic                     mem_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy
);
  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3, S_LAST, S_RESP} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_last_d;
  logic [ADDRESS_WIDTH-1:0] r_base;
  logic [ADDRESS_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0]    r_b0;
  logic [DATA_WIDTH-1:0]    r_b1;
  logic [DATA_WIDTH-1:0]    r_b2;
  logic [31:0]              r_f_rdata;
  logic [31:0]              r_d_rdata;
  logic                     w_pick_d;
  logic [ADDRESS_WIDTH-1:0] w_base;
  logic [ADDRESS_WIDTH-1:0] w_off;
  logic                     w_rd;
  logic [31:0]              w_word;
  logic                     w_unused;

  // data wins only when alone or when fetch took the previous grant
  assign w_pick_d = d_req & (~f_req | ~r_last_d);
  assign w_base   = w_pick_d ? {d_addr[ADDRESS_WIDTH-1:2], 2'b00} : {f_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign w_word   = {r_b0, r_b1, r_b2, mem_rdata};
  assign w_unused = &{f_addr[31:ADDRESS_WIDTH], f_addr[1:0], d_addr[31:ADDRESS_WIDTH], d_addr[1:0]};
  assign f_rdata  = r_f_rdata;
  assign d_rdata  = r_d_rdata;

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;

  // next state: IDLE waits for a request, RESP returns to IDLE, the rest step in order
  always_comb begin
    w_next = r_state == S_IDLE ? ((f_req | d_req) ? S_B0 : S_IDLE) :
             r_state == S_RESP ? S_IDLE : state_t'(r_state + 3'd1);
  end

  // memory port and ack outputs decoded from the current state
  always_comb begin
    w_rd     = r_state inside {S_B0, S_B1, S_B2, S_B3};
    w_off    = r_state == S_B3 ? ADDRESS_WIDTH'(3) :
               r_state == S_B2 ? ADDRESS_WIDTH'(2) :
               r_state == S_B1 ? ADDRESS_WIDTH'(1) : '0;
    mem_en   = w_rd;
    mem_addr = w_rd ? r_base + w_off : r_hold;
    f_ack    = r_state == S_RESP && !r_last_d;
    d_ack    = r_state == S_RESP && r_last_d;
    busy     = r_state != S_IDLE;
  end

  // grant/base latch, byte capture one cycle behind each read, word commit on LAST
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_last_d  <= 1'b1;
      r_base    <= '0;
      r_hold    <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_b2      <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else if (r_state == S_IDLE && (f_req || d_req)) begin
      r_last_d <= w_pick_d;
      r_base   <= w_base;
    end else if (r_state == S_B1) r_b0 <= mem_rdata;
    else if (r_state == S_B2) r_b1 <= mem_rdata;
    else if (r_state == S_B3) begin
      r_b2   <= mem_rdata;
      r_hold <= mem_addr;
    end else if (r_state == S_LAST) begin
      if (r_last_d) r_d_rdata <= w_word;
      else          r_f_rdata <= w_word;
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter with a synchronous byte memory model
module tb_imem_arbiter;
  logic        clk = 0;
  logic        rst = 0;
  logic        f_req = 0;
  logic [31:0] f_addr = 0;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        d_req = 0;
  logic [31:0] d_addr = 0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_rdata = 0;
  logic        busy;

  imem_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [32];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int          n_run = 0;
  int          n_fail = 0;
  bit          qp[$];
  logic [31:0] qw[$];
  int          qc[$];
  logic [4:0]  qa[$];
  logic [31:0] exp_f = 0;
  logic [31:0] exp_d = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input int b);
    return {mem[b & 31], mem[(b + 1) & 31], mem[(b + 2) & 31], mem[(b + 3) & 31]};
  endfunction

  task automatic expect_txn(input bit p, input int a, input int c);
    int b;
    b = a & 28;
    qp.push_back(p);
    qw.push_back(word_at(b));
    qc.push_back(c);
    for (int k = 0; k < 4; k++) qa.push_back(5'((b + k) & 31));
  endtask

  task automatic check_reset_outputs();
    chk("rst_f_ack", {31'b0, f_ack}, 0);
    chk("rst_d_ack", {31'b0, d_ack}, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_addr", {27'b0, mem_addr}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
  endtask

  task automatic run_single(input bit p, input int a);
    int c0;
    c0 = cyc;
    if (p) begin d_addr = a; d_req = 1; end
    else   begin f_addr = a; f_req = 1; end
    expect_txn(p, a, c0 + 6);
    repeat (6) @(negedge clk);
    f_req = 0;
    d_req = 0;
    @(negedge clk);
  endtask

  bit          m_p;
  logic [31:0] m_w;
  int          m_c;
  always @(negedge clk) if (rst) begin
    chk("dual_ack", {31'b0, f_ack & d_ack}, 0);
    if (f_ack || d_ack) begin
      if (qp.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_ack: f_ack=%b d_ack=%b at cycle %0d, none expected", f_ack, d_ack, cyc);
      end else begin
        m_p = qp.pop_front();
        m_w = qw.pop_front();
        m_c = qc.pop_front();
        chk("ack_port", {31'b0, d_ack}, {31'b0, m_p});
        chk("ack_cycle", 32'(cyc), 32'(m_c));
        if (m_p) exp_d = m_w;
        else     exp_f = m_w;
      end
    end
    chk("f_rdata", f_rdata, exp_f);
    chk("d_rdata", d_rdata, exp_d);
    if (mem_en) begin
      if (qa.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_read: mem_addr=%h at cycle %0d, none expected", mem_addr, cyc);
      end else chk("mem_addr", {27'b0, mem_addr}, {27'b0, qa.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h13;
    mem[1] = 8'h00;
    mem[2] = 8'h50;
    mem[3] = 8'h00;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    // single fetch at base 0
    run_single(0, 32'h00);
    // misaligned fetch and out-of-range data address
    run_single(0, 32'h1E);
    run_single(1, 32'h23);
    // contention: both held across four grants
    c0 = cyc;
    f_addr = 32'h08;
    d_addr = 32'h10;
    f_req = 1;
    d_req = 1;
    expect_txn(0, 32'h08, c0 + 6);
    expect_txn(1, 32'h10, c0 + 13);
    expect_txn(0, 32'h08, c0 + 20);
    expect_txn(1, 32'h10, c0 + 27);
    repeat (27) @(negedge clk);
    f_req = 0;
    d_req = 0;
    @(negedge clk);
    // late data request during a fetch
    c0 = cyc;
    f_addr = 32'h04;
    f_req = 1;
    expect_txn(0, 32'h04, c0 + 6);
    repeat (2) @(negedge clk);
    d_addr = 32'h14;
    d_req = 1;
    expect_txn(1, 32'h14, c0 + 13);
    repeat (4) @(negedge clk);
    f_req = 0;
    repeat (7) @(negedge clk);
    d_req = 0;
    @(negedge clk);
    // reset during B2
    f_addr = 32'h18;
    f_req = 1;
    qa.push_back(5'h18);
    qa.push_back(5'h19);
    qa.push_back(5'h1A);
    repeat (3) @(negedge clk);
    #1;
    rst = 0;
    f_req = 0;
    exp_f = 0;
    exp_d = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    run_single(0, 32'h18);
    // protocol violation: address changes and request drops mid-transaction
    c0 = cyc;
    f_addr = 32'h0C;
    f_req = 1;
    expect_txn(0, 32'h0C, c0 + 6);
    repeat (2) @(negedge clk);
    f_addr = 32'h00;
    @(negedge clk);
    f_req = 0;
    repeat (4) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("ack_queue_empty", 32'(qp.size()), 0);
    chk("addr_queue_empty", 32'(qa.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
